// File: rtl/ps2_scan_receiver.sv
// PS/2 device-to-host frame receiver.
// Brings the raw PS/2 clock and data pins into the Clk domain and deserialises
// 11-bit frames: start, 8 data bits LSB first, odd parity, stop.
// A watchdog discards any frame that stalls. E0 (extended) and F0 (break)
// prefix bytes are folded into flags, and one qualified scan code is emitted
// for each key event. The break flag appears on the key_release output.
module ps2_scan_receiver #(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int CNT_W          = 16
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       psClk,
  input  logic       psData,
  output logic [7:0] scan_code,
  output logic       extended,
  output logic       key_release,
  output logic       code_valid,
  output logic       frame_err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  // Reset: asserted asynchronously, released synchronously.
  logic [1:0] rst_sync;
  logic       rst;

  // Synchronisers and the delayed clock sample used for edge detection.
  logic [SYNC_STAGES-1:0] clk_sync;
  logic [SYNC_STAGES-1:0] data_sync;
  logic                   clk_last;
  logic                   sync_clk;
  logic                   sync_data;
  logic                   fall;

  // Frame state.
  state_t           state;
  state_t           state_d;
  logic [7:0]       shreg;
  logic [2:0]       bit_cnt;
  logic [CNT_W-1:0] wd_cnt;
  logic             par_ok;
  logic             ext_pend;
  logic             rel_pend;

  // Per-cycle strobes from the FSM.
  logic start;
  logic shift_en;
  logic par_en;
  logic stop_en;
  logic timeout;
  logic frame_good;
  logic is_e0;
  logic is_f0;
  logic emit;
  logic drop;

  // Stretch the external reset so its release is aligned to Clk.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      rst_sync <= '1;
    end else begin
      rst_sync <= {rst_sync[0], 1'b0};
    end
  end

  assign rst = rst_sync[1];

  // Pin synchronisers; reset to 1 so the idle-high bus gives no false edge on release.
  always_ff @(posedge Clk or posedge rst) begin
    if (rst) begin
      clk_sync  <= '1;
      data_sync <= '1;
      clk_last  <= 1'b1;
    end else begin
      clk_sync  <= {clk_sync[SYNC_STAGES-2:0], psClk};
      data_sync <= {data_sync[SYNC_STAGES-2:0], psData};
      clk_last  <= clk_sync[SYNC_STAGES-1];
    end
  end

  assign sync_clk  = clk_sync[SYNC_STAGES-1];
  assign sync_data = data_sync[SYNC_STAGES-1];
  assign fall      = clk_last & ~sync_clk;

  // The watchdog only matters inside a frame; a fall in the expiry cycle is lost.
  assign timeout = (state != S_IDLE) && (wd_cnt == WD_LAST);

  // Frame state register.
  always_ff @(posedge Clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_d;
    end
  end

  // Next-state logic and per-bit strobes, advancing once per psClk falling edge.
  always_comb begin
    state_d  = state;
    start    = 1'b0;
    shift_en = 1'b0;
    par_en   = 1'b0;
    stop_en  = 1'b0;
    if (timeout) begin
      state_d = S_IDLE;
    end else if (fall) begin
      case (state)
        S_IDLE: begin
          // A falling edge with data high is not a start bit; ignore it.
          if (!sync_data) begin
            state_d = S_DATA;
            start   = 1'b1;
          end
        end
        S_DATA: begin
          shift_en = 1'b1;
          if (bit_cnt == 3'd7) begin
            state_d = S_PARITY;
          end
        end
        S_PARITY: begin
          par_en  = 1'b1;
          state_d = S_STOP;
        end
        S_STOP: begin
          stop_en = 1'b1;
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign frame_good = stop_en & sync_data & par_ok;
  assign is_e0      = (shreg == 8'hE0);
  assign is_f0      = (shreg == 8'hF0);
  assign emit       = frame_good & ~is_e0 & ~is_f0;
  assign drop       = (stop_en & ~(sync_data & par_ok)) | timeout;

  // Shift register, bit counter, parity latch and watchdog.
  always_ff @(posedge Clk or posedge rst) begin
    if (rst) begin
      shreg   <= '0;
      bit_cnt <= '0;
      par_ok  <= 1'b0;
      wd_cnt  <= '0;
    end else begin
      if (start) begin
        bit_cnt <= '0;
      end else if (shift_en) begin
        bit_cnt <= bit_cnt + 3'd1;
      end
      if (shift_en) begin
        shreg <= {sync_data, shreg[7:1]};
      end
      if (par_en) begin
        par_ok <= ^{shreg, sync_data};
      end
      if ((state == S_IDLE) || fall) begin
        wd_cnt <= '0;
      end else begin
        wd_cnt <= wd_cnt + CNT_W'(1);
      end
    end
  end

  // Prefix flags survive idle time and are consumed by a data byte or an error.
  always_ff @(posedge Clk or posedge rst) begin
    if (rst) begin
      ext_pend <= 1'b0;
      rel_pend <= 1'b0;
    end else if (drop || emit) begin
      ext_pend <= 1'b0;
      rel_pend <= 1'b0;
    end else if (frame_good) begin
      if (is_e0) begin
        ext_pend <= 1'b1;
      end
      if (is_f0) begin
        rel_pend <= 1'b1;
      end
    end
  end

  // Output registers: one-cycle strobes plus scan code fields held until the next event.
  always_ff @(posedge Clk or posedge rst) begin
    if (rst) begin
      scan_code   <= '0;
      extended    <= 1'b0;
      key_release <= 1'b0;
      code_valid  <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      code_valid <= emit;
      frame_err  <= drop;
      if (emit) begin
        scan_code   <= shreg;
        extended    <= ext_pend;
        key_release <= rel_pend;
      end
    end
  end

endmodule

// File: tb/tb_ps2_scan_receiver.sv
// Self-checking bench for ps2_scan_receiver: a PS/2 device model drives frames,
// a monitor records every code_valid/frame_err pulse, and a byte-level model
// predicts the event each frame should produce.
module tb_ps2_scan_receiver;

  localparam int SYNC = 2;
  localparam int TOUT = 200;
  localparam int LAT  = SYNC + 1;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       psClk;
  logic       psData;
  logic [7:0] scan_code;
  logic       extended;
  logic       key_release;
  logic       code_valid;
  logic       frame_err;

  ps2_scan_receiver #(
    .SYNC_STAGES   (SYNC),
    .TIMEOUT_CYCLES(TOUT),
    .CNT_W         (16)
  ) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .psClk      (psClk),
    .psData     (psData),
    .scan_code  (scan_code),
    .extended   (extended),
    .key_release(key_release),
    .code_valid (code_valid),
    .frame_err  (frame_err)
  );

  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  typedef struct packed {
    logic       err;
    logic [7:0] code;
    logic       ext;
    logic       rel;
    int         cyc;
  } ev_t;

  ev_t  evq[$];
  ev_t  mon_e;
  int   overlap_cnt = 0;
  int   long_cnt = 0;
  logic prev_cv = 1'b0;
  logic prev_fe = 1'b0;

  // Monitor: log every output pulse and note pulse-shape violations.
  always @(negedge Clk) begin
    if (code_valid === 1'b1 || frame_err === 1'b1) begin
      mon_e.err  = frame_err;
      mon_e.code = scan_code;
      mon_e.ext  = extended;
      mon_e.rel  = key_release;
      mon_e.cyc  = cyc;
      evq.push_back(mon_e);
    end
    if (code_valid === 1'b1 && frame_err === 1'b1) overlap_cnt++;
    if ((code_valid === 1'b1 && prev_cv === 1'b1) || (frame_err === 1'b1 && prev_fe === 1'b1)) long_cnt++;
    prev_cv = code_valid;
    prev_fe = frame_err;
  end

  int checks = 0;
  int errors = 0;
  int last_fall = 0;

  // Reference model state: pending prefixes and the currently held outputs.
  bit         m_ext = 1'b0;
  bit         m_rel = 1'b0;
  logic [7:0] m_code = 8'h00;
  bit         m_xo = 1'b0;
  bit         m_ro = 1'b0;

  function automatic logic [31:0] pack(input int n, input bit err, input bit ext, input bit rel,
                                       input logic [7:0] code, input int lat);
    return {4'(n), 3'b0, err, 3'b0, ext, 3'b0, rel, code, 8'(lat)};
  endfunction

  // Expected outcome of one complete frame at byte level.
  function automatic logic [31:0] model_frame(input logic [7:0] b, input bit bad);
    if (bad) begin
      m_ext = 1'b0;
      m_rel = 1'b0;
      return pack(1, 1'b1, 1'b0, 1'b0, 8'h00, LAT);
    end
    if (b == 8'hE0) begin
      m_ext = 1'b1;
      return pack(0, 1'b0, 1'b0, 1'b0, 8'h00, 0);
    end
    if (b == 8'hF0) begin
      m_rel = 1'b1;
      return pack(0, 1'b0, 1'b0, 1'b0, 8'h00, 0);
    end
    m_code = b;
    m_xo   = m_ext;
    m_ro   = m_rel;
    m_ext  = 1'b0;
    m_rel  = 1'b0;
    return pack(1, 1'b0, m_xo, m_ro, b, LAT);
  endfunction

  function automatic void model_reset();
    m_ext  = 1'b0;
    m_rel  = 1'b0;
    m_code = 8'h00;
    m_xo   = 1'b0;
    m_ro   = 1'b0;
  endfunction

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  // One PS/2 bit: data changes mid-high, 20-cycle half periods.
  task automatic send_bit(input bit b);
    wait_cyc(10);
    psData = b;
    wait_cyc(10);
    psClk = 1'b0;
    last_fall = cyc;
    wait_cyc(20);
    psClk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
    send_bit(1'b0);
    for (int unsigned i = 0; i < 8; i++) send_bit(b[i]);
    send_bit((~^b) ^ bad_par);
    send_bit(~bad_stop);
    psData = 1'b1;
  endtask

  // Summarise what the monitor saw since the last call.
  task automatic observe(output logic [31:0] obs);
    ev_t e;
    int  n;
    n = evq.size();
    if (n == 0) begin
      obs = pack(0, 1'b0, 1'b0, 1'b0, 8'h00, 0);
    end else begin
      e = evq[0];
      if (e.err) obs = pack(n, 1'b1, 1'b0, 1'b0, 8'h00, e.cyc - last_fall);
      else       obs = pack(n, 1'b0, e.ext, e.rel, e.code, e.cyc - last_fall);
    end
    evq.delete();
  endtask

  task automatic frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                       output logic [31:0] exp, output logic [31:0] obs);
    exp = model_frame(b, bad_par | bad_stop);
    send_frame(b, bad_par, bad_stop);
    wait_cyc(30);
    observe(obs);
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    psClk = 1'b1;
    psData = 1'b1;
    wait_cyc(4);
    checks++;
    if ({scan_code, extended, key_release, code_valid, frame_err} !== 12'h000) begin
      errors++;
      $display("FAIL reset_hold: outputs got %h expected 000", {scan_code, extended, key_release, code_valid, frame_err});
    end
    Reset = 1'b0;
    wait_cyc(6);
    checks++;
    if ({scan_code, extended, key_release, code_valid, frame_err} !== 12'h000) begin
      errors++;
      $display("FAIL reset_release: outputs got %h expected 000", {scan_code, extended, key_release, code_valid, frame_err});
    end
    model_reset();
    evq.delete();
  endtask

  task automatic test_make();
    logic [31:0] exp, obs;
    frame(8'h1C, 1'b0, 1'b0, exp, obs);
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL make: result got %h expected %h", obs, exp); end
    checks++;
    if ({scan_code, extended, key_release} !== {m_code, m_xo, m_ro}) begin
      errors++; $display("FAIL make_hold: got %h expected %h", {scan_code, extended, key_release}, {m_code, m_xo, m_ro});
    end
  endtask

  task automatic test_prefixes();
    logic [7:0]  seq [6] = '{8'hF0, 8'h1C, 8'hE0, 8'hF0, 8'h75, 8'h75};
    logic [31:0] exp, obs;
    for (int unsigned i = 0; i < 6; i++) begin
      frame(seq[i], 1'b0, 1'b0, exp, obs);
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL prefix frame %0d: result got %h expected %h", i, obs, exp); end
      checks++;
      if ({scan_code, extended, key_release} !== {m_code, m_xo, m_ro}) begin
        errors++; $display("FAIL prefix_hold frame %0d: got %h expected %h", i, {scan_code, extended, key_release}, {m_code, m_xo, m_ro});
      end
    end
  endtask

  task automatic test_frame_errors();
    logic [7:0]  seq [5] = '{8'hE0, 8'h1D, 8'h1D, 8'h3A, 8'h3A};
    bit          bp  [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    bit          bs  [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [31:0] exp, obs;
    for (int unsigned i = 0; i < 5; i++) begin
      frame(seq[i], bp[i], bs[i], exp, obs);
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL ferr frame %0d: result got %h expected %h", i, obs, exp); end
      checks++;
      if ({scan_code, extended, key_release} !== {m_code, m_xo, m_ro}) begin
        errors++; $display("FAIL ferr_hold frame %0d: got %h expected %h", i, {scan_code, extended, key_release}, {m_code, m_xo, m_ro});
      end
    end
  endtask

  task automatic test_idle_glitch();
    logic [31:0] exp, obs;
    send_bit(1'b1);
    wait_cyc(30);
    observe(obs);
    checks++;
    if (obs !== pack(0, 1'b0, 1'b0, 1'b0, 8'h00, 0)) begin
      errors++; $display("FAIL idle_glitch: result got %h expected 0", obs);
    end
    frame(8'h29, 1'b0, 1'b0, exp, obs);
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL after_glitch: result got %h expected %h", obs, exp); end
  endtask

  task automatic test_timeout();
    logic [31:0] exp, obs;
    frame(8'hF0, 1'b0, 1'b0, exp, obs);
    send_bit(1'b0);
    for (int unsigned i = 0; i < 3; i++) send_bit(1'($urandom_range(0, 1)));
    psData = 1'b1;
    wait_cyc(TOUT + 60);
    observe(obs);
    m_ext = 1'b0;
    m_rel = 1'b0;
    exp = pack(1, 1'b1, 1'b0, 1'b0, 8'h00, LAT + TOUT);
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL timeout: result got %h expected %h", obs, exp); end
    checks++;
    if ({scan_code, extended, key_release} !== {m_code, m_xo, m_ro}) begin
      errors++; $display("FAIL timeout_hold: got %h expected %h", {scan_code, extended, key_release}, {m_code, m_xo, m_ro});
    end
    frame(8'h2B, 1'b0, 1'b0, exp, obs);
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL after_timeout: result got %h expected %h", obs, exp); end
  endtask

  task automatic test_reset_midframe();
    logic [31:0] exp, obs;
    logic [7:0]  b = 8'h74;
    frame(8'hE0, 1'b0, 1'b0, exp, obs);
    send_bit(1'b0);
    for (int unsigned i = 0; i < 4; i++) send_bit(b[i]);
    psData = 1'b1;
    wait_cyc(3);
    Reset = 1'b1;
    #2;
    checks++;
    if ({scan_code, extended, key_release, code_valid, frame_err} !== 12'h000) begin
      errors++; $display("FAIL midframe_reset: outputs got %h expected 000", {scan_code, extended, key_release, code_valid, frame_err});
    end
    wait_cyc(3);
    Reset = 1'b0;
    wait_cyc(6);
    model_reset();
    evq.delete();
    frame(8'h74, 1'b0, 1'b0, exp, obs);
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL after_reset: result got %h expected %h", obs, exp); end
    checks++;
    if ({scan_code, extended, key_release} !== 10'h1D0) begin
      errors++; $display("FAIL after_reset_hold: got %h expected 1d0", {scan_code, extended, key_release});
    end
  endtask

  task automatic test_random();
    logic [31:0] exp, obs;
    logic [7:0]  b;
    bit          bp, bs;
    int          r;
    for (int i = 0; i < 30; i++) begin
      r  = int'($urandom_range(0, 99));
      bp = 1'b0;
      bs = 1'b0;
      b  = 8'($urandom_range(0, 255));
      if (r < 20)      b = 8'hE0;
      else if (r < 40) b = 8'hF0;
      else if (r < 48) bp = 1'b1;
      else if (r < 53) bs = 1'b1;
      frame(b, bp, bs, exp, obs);
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL random frame %0d byte %h: result got %h expected %h", i, b, obs, exp); end
      checks++;
      if ({scan_code, extended, key_release} !== {m_code, m_xo, m_ro}) begin
        errors++; $display("FAIL random_hold frame %0d: got %h expected %h", i, {scan_code, extended, key_release}, {m_code, m_xo, m_ro});
      end
    end
  endtask

  task automatic test_pulse_rules();
    checks++;
    if (overlap_cnt !== 0) begin errors++; $display("FAIL pulse_overlap: count got %0d expected 0", overlap_cnt); end
    checks++;
    if (long_cnt !== 0) begin errors++; $display("FAIL pulse_width: count got %0d expected 0", long_cnt); end
  endtask

  initial begin
    test_reset();
    test_make();
    test_prefixes();
    test_frame_errors();
    test_idle_glitch();
    test_timeout();
    test_reset_midframe();
    test_random();
    test_pulse_rules();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: simulation time limit reached");
    $fatal(1);
  end

endmodule
